// File: rtl/csr_init_pkg.sv
// csr_init_pkg: shared types for the CSR initiator.
// State encoding, wait-counter width and the command record used by
// producers of the command stream. The MERGE state is only reachable
// when the design is built with CSR_INIT_RMW_EN.
package csr_init_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    RD_WAIT = 3'd3,
    MERGE   = 3'd4,
    RSP     = 3'd5
  } csr_init_state_t;

  // Wide enough for RD_LATENCY-1 with RD_LATENCY up to 7.
  localparam int RD_CNT_W = 3;

  // Default CSR map geometry; the command record is sized by these.
  localparam int CSR_ADDR_W = 8;
  localparam int CSR_DATA_W = 32;

  typedef struct packed {
    logic                  we;
    logic [CSR_ADDR_W-1:0] addr;
    logic [CSR_DATA_W-1:0] wdata;
    logic [CSR_DATA_W-1:0] mask;
  } csr_init_cmd_t;

endpackage

// File: rtl/csr_initiator.sv
// csr_initiator: bus-master end of the CSR interface.
// Accepts one valid/ready command at a time, issues a single-cycle
// reg_wr_en_o or reg_rd_en_o strobe, captures registered read data after
// RD_LATENCY cycles and returns it on a valid/ready response stream.
// Optional build macro CSR_INIT_RMW_EN adds cmd_mask_i and a
// read-merge-write path for partially masked writes.
module csr_initiator
  import csr_init_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              reg_clk_i,
  input  logic              reg_rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
`ifdef CSR_INIT_RMW_EN
  input  logic [DATA_W-1:0] cmd_mask_i,
`endif
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_we_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              reg_wr_en_o,
  output logic              reg_rd_en_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [DATA_W-1:0] reg_wr_data_o,
  input  logic [DATA_W-1:0] reg_rd_data_i,
  output logic              busy_o
);

  csr_init_state_t     state_reg;
  csr_init_state_t     state_next;
  logic [RD_CNT_W-1:0] rd_cnt_reg;
  logic                cmd_ready_reg;
  logic                rsp_valid_reg;
  logic                rsp_we_reg;
  logic [DATA_W-1:0]   rsp_rdata_reg;
  logic                reg_wr_en_reg;
  logic                reg_rd_en_reg;
  logic [ADDR_W-1:0]   reg_addr_reg;
  logic [DATA_W-1:0]   reg_wr_data_reg;
  logic                cmd_accept;
  logic                rmw_req;
  logic                rd_cnt_zero;

  assign cmd_accept  = cmd_valid_i && cmd_ready_reg;
  assign rd_cnt_zero = (rd_cnt_reg == '0);

`ifdef CSR_INIT_RMW_EN
  logic [DATA_W-1:0] cmd_mask_reg;

  // A write needs the read-merge path unless every bit is enabled.
  assign rmw_req = (cmd_mask_i != '1);
`else
  assign rmw_req = 1'b0;
`endif

  // State register.
  always_ff @(posedge reg_clk_i or posedge reg_rst_i) begin
    if (reg_rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode; one transaction in flight, stalls only in RSP.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_accept) begin
          state_next = (cmd_we_i && !rmw_req) ? WR : RD;
        end
      end
      WR:      state_next = RSP;
      RD:      state_next = RD_WAIT;
      RD_WAIT: begin
        if (rd_cnt_zero) begin
`ifdef CSR_INIT_RMW_EN
          // A write that reached RD_WAIT is a masked write: merge next.
          state_next = rsp_we_reg ? MERGE : RSP;
`else
          state_next = RSP;
`endif
        end
      end
`ifdef CSR_INIT_RMW_EN
      MERGE:   state_next = WR;
`endif
      RSP: begin
        if (rsp_ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs and datapath. Handshake/strobe flags are decoded
  // from the next state so they line up exactly with the state they
  // belong to; one flop each keeps the strobes glitch-free.
  always_ff @(posedge reg_clk_i or posedge reg_rst_i) begin
    if (reg_rst_i) begin
      cmd_ready_reg   <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_we_reg      <= 1'b0;
      rsp_rdata_reg   <= '0;
      reg_wr_en_reg   <= 1'b0;
      reg_rd_en_reg   <= 1'b0;
      reg_addr_reg    <= '0;
      reg_wr_data_reg <= '0;
      rd_cnt_reg      <= '0;
    end else begin
      cmd_ready_reg <= (state_next == IDLE);
      reg_wr_en_reg <= (state_next == WR);
      reg_rd_en_reg <= (state_next == RD);
      rsp_valid_reg <= (state_next == RSP);

      // Address and write data hold from one acceptance to the next.
      if (cmd_accept) begin
        reg_addr_reg    <= cmd_addr_i;
        reg_wr_data_reg <= cmd_wdata_i;
        rsp_we_reg      <= cmd_we_i;
        rsp_rdata_reg   <= '0;
      end

      // Wait counter: loaded during the read strobe, counts down to 0.
      if (state_reg == RD) begin
        rd_cnt_reg <= RD_CNT_W'(RD_LATENCY - 1);
      end else if ((state_reg == RD_WAIT) && !rd_cnt_zero) begin
        rd_cnt_reg <= rd_cnt_reg - RD_CNT_W'(1);
      end

      // Read data is sampled only on the capture cycle.
      if ((state_reg == RD_WAIT) && rd_cnt_zero) begin
        rsp_rdata_reg <= reg_rd_data_i;
      end

`ifdef CSR_INIT_RMW_EN
      // Merge the read-back value with the enabled bits of the write data;
      // reg_wr_data_reg still holds the original write data here.
      if (state_reg == MERGE) begin
        reg_wr_data_reg <= (rsp_rdata_reg & ~cmd_mask_reg) |
                           (reg_wr_data_reg & cmd_mask_reg);
      end
`endif
    end
  end

`ifdef CSR_INIT_RMW_EN
  // Mask captured alongside the rest of the command.
  always_ff @(posedge reg_clk_i or posedge reg_rst_i) begin
    if (reg_rst_i) begin
      cmd_mask_reg <= '0;
    end else if (cmd_accept) begin
      cmd_mask_reg <= cmd_mask_i;
    end
  end
`endif

  assign cmd_ready_o   = cmd_ready_reg;
  assign rsp_valid_o   = rsp_valid_reg;
  assign rsp_we_o      = rsp_we_reg;
  assign rsp_rdata_o   = rsp_rdata_reg;
  assign reg_wr_en_o   = reg_wr_en_reg;
  assign reg_rd_en_o   = reg_rd_en_reg;
  assign reg_addr_o    = reg_addr_reg;
  assign reg_wr_data_o = reg_wr_data_reg;
  assign busy_o        = (state_reg != IDLE);

endmodule

// File: tb/tb_csr_initiator.sv
// tb_csr_initiator: two initiator instances (RD_LATENCY 1 and 4) driven by
// directed and random commands. Each lane has a CSR memory array; expected
// strobes, timing and response data follow from the protocol rules applied
// per transaction. CSR_INIT_RMW_EN enables masked-write stimulus.
module tb_csr_initiator;
  import csr_init_pkg::*;

  localparam int NL   = 2;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int LAT0 = 1;
  localparam int LAT1 = 4;

  logic          reg_clk = 1'b0;
  logic          rst       [NL];
  logic          cmd_valid [NL];
  logic          cmd_ready [NL];
  logic          cmd_we    [NL];
  logic [AW-1:0] cmd_addr  [NL];
  logic [DW-1:0] cmd_wdata [NL];
`ifdef CSR_INIT_RMW_EN
  logic [DW-1:0] cmd_mask  [NL];
`endif
  logic          rsp_valid [NL];
  logic          rsp_ready [NL];
  logic          rsp_we    [NL];
  logic [DW-1:0] rsp_rdata [NL];
  logic          wr_en     [NL];
  logic          rd_en     [NL];
  logic [AW-1:0] reg_addr  [NL];
  logic [DW-1:0] wr_data   [NL];
  logic [DW-1:0] rd_data   [NL];
  logic          busy      [NL];

  logic [DW-1:0] mem [NL][256];
  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 reg_clk = ~reg_clk;

  for (genvar gi = 0; gi < NL; gi++) begin : g_lane
    csr_initiator #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .RD_LATENCY((gi == 0) ? LAT0 : LAT1)
    ) u_dut (
      .reg_clk_i    (reg_clk),
      .reg_rst_i    (rst[gi]),
      .cmd_valid_i  (cmd_valid[gi]),
      .cmd_ready_o  (cmd_ready[gi]),
      .cmd_we_i     (cmd_we[gi]),
      .cmd_addr_i   (cmd_addr[gi]),
      .cmd_wdata_i  (cmd_wdata[gi]),
`ifdef CSR_INIT_RMW_EN
      .cmd_mask_i   (cmd_mask[gi]),
`endif
      .rsp_valid_o  (rsp_valid[gi]),
      .rsp_ready_i  (rsp_ready[gi]),
      .rsp_we_o     (rsp_we[gi]),
      .rsp_rdata_o  (rsp_rdata[gi]),
      .reg_wr_en_o  (wr_en[gi]),
      .reg_rd_en_o  (rd_en[gi]),
      .reg_addr_o   (reg_addr[gi]),
      .reg_wr_data_o(wr_data[gi]),
      .reg_rd_data_i(rd_data[gi]),
      .busy_o       (busy[gi])
    );
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input int ln);
    return (ln == 0) ? LAT0 : LAT1;
  endfunction

  // Outputs that must be quiet: no strobe, no response.
  task automatic check_quiet(input int ln, input string tag);
    check_eq($sformatf("L%0d %s wr_en", ln, tag), 64'(wr_en[ln]), 64'd0);
    check_eq($sformatf("L%0d %s rd_en", ln, tag), 64'(rd_en[ln]), 64'd0);
    check_eq($sformatf("L%0d %s rsp_valid", ln, tag), 64'(rsp_valid[ln]), 64'd0);
  endtask

  task automatic check_all_zero(input int ln, input string tag);
    check_quiet(ln, tag);
    check_eq($sformatf("L%0d %s cmd_ready", ln, tag), 64'(cmd_ready[ln]), 64'd0);
    check_eq($sformatf("L%0d %s busy", ln, tag), 64'(busy[ln]), 64'd0);
    check_eq($sformatf("L%0d %s addr", ln, tag), 64'(reg_addr[ln]), 64'd0);
    check_eq($sformatf("L%0d %s wdata", ln, tag), 64'(wr_data[ln]), 64'd0);
    check_eq($sformatf("L%0d %s rdata", ln, tag), 64'(rsp_rdata[ln]), 64'd0);
    check_eq($sformatf("L%0d %s rsp_we", ln, tag), 64'(rsp_we[ln]), 64'd0);
  endtask

  task automatic junk_cmd(input int ln, input logic valid);
    cmd_valid[ln] = valid;
    cmd_we[ln]    = 1'($urandom);
    cmd_addr[ln]  = AW'($urandom);
    cmd_wdata[ln] = $urandom;
`ifdef CSR_INIT_RMW_EN
    cmd_mask[ln]  = $urandom;
`endif
  endtask

  // One complete command/response exchange on lane ln; all samples taken
  // on the falling edge, N0 being the falling edge after acceptance.
  task automatic do_txn(input int ln, input csr_init_cmd_t c, input int stall);
    logic [DW-1:0] old, exp_wr, exp_rd;
    int lat, n;
    bit rmw;
    lat = lat_of(ln);
    rmw = 1'b0;
`ifdef CSR_INIT_RMW_EN
    rmw = c.we && (c.mask != 32'hFFFF_FFFF);
`endif
    old    = mem[ln][c.addr];
    exp_wr = rmw ? ((old & ~c.mask) | (c.wdata & c.mask)) : c.wdata;
    exp_rd = c.we && !rmw ? 32'd0 : old;

    cmd_valid[ln] = 1'b1;
    cmd_we[ln]    = c.we;
    cmd_addr[ln]  = c.addr;
    cmd_wdata[ln] = c.wdata;
`ifdef CSR_INIT_RMW_EN
    cmd_mask[ln]  = c.mask;
`endif
    rsp_ready[ln] = 1'b0;
    n = 0;
    while (!cmd_ready[ln] && n < 20) begin
      @(negedge reg_clk);
      n++;
    end
    if (!cmd_ready[ln]) begin
      check_eq($sformatf("L%0d cmd_ready timeout", ln), 64'(cmd_ready[ln]), 64'd1);
      cmd_valid[ln] = 1'b0;
      return;
    end
    @(negedge reg_clk);
    junk_cmd(ln, 1'($urandom));
    rd_data[ln] = $urandom;
    check_eq($sformatf("L%0d cmd_ready after accept", ln), 64'(cmd_ready[ln]), 64'd0);
    check_eq($sformatf("L%0d busy", ln), 64'(busy[ln]), 64'd1);
    check_eq($sformatf("L%0d strobe addr", ln), 64'(reg_addr[ln]), 64'(c.addr));
    if (c.we && !rmw) begin
      check_eq($sformatf("L%0d wr strobe", ln), 64'(wr_en[ln]), 64'd1);
      check_eq($sformatf("L%0d rd during wr", ln), 64'(rd_en[ln]), 64'd0);
      check_eq($sformatf("L%0d wr data", ln), 64'(wr_data[ln]), 64'(exp_wr));
      mem[ln][c.addr] = exp_wr;
    end else begin
      check_eq($sformatf("L%0d rd strobe", ln), 64'(rd_en[ln]), 64'd1);
      check_eq($sformatf("L%0d wr during rd", ln), 64'(wr_en[ln]), 64'd0);
      for (int i = 1; i <= lat; i++) begin
        @(negedge reg_clk);
        rd_data[ln] = (i == lat) ? old : $urandom;
        check_quiet(ln, $sformatf("rd wait %0d", i));
      end
      if (rmw) begin
        @(negedge reg_clk);
        rd_data[ln] = $urandom;
        check_quiet(ln, "merge");
        @(negedge reg_clk);
        check_eq($sformatf("L%0d rmw wr strobe", ln), 64'(wr_en[ln]), 64'd1);
        check_eq($sformatf("L%0d rmw rd strobe", ln), 64'(rd_en[ln]), 64'd0);
        check_eq($sformatf("L%0d rmw wr data", ln), 64'(wr_data[ln]), 64'(exp_wr));
        check_eq($sformatf("L%0d rmw addr", ln), 64'(reg_addr[ln]), 64'(c.addr));
        mem[ln][c.addr] = exp_wr;
      end
    end
    @(negedge reg_clk);
    rd_data[ln] = $urandom;
    check_eq($sformatf("L%0d rsp_valid", ln), 64'(rsp_valid[ln]), 64'd1);
    check_eq($sformatf("L%0d rsp_we", ln), 64'(rsp_we[ln]), 64'(c.we));
    check_eq($sformatf("L%0d rsp_rdata", ln), 64'(rsp_rdata[ln]), 64'(exp_rd));
    check_eq($sformatf("L%0d strobe in rsp", ln), 64'(wr_en[ln] | rd_en[ln]), 64'd0);
    for (int s = 0; s < stall; s++) begin
      junk_cmd(ln, 1'b1);
      @(negedge reg_clk);
      check_eq($sformatf("L%0d stall rsp_valid", ln), 64'(rsp_valid[ln]), 64'd1);
      check_eq($sformatf("L%0d stall rdata", ln), 64'(rsp_rdata[ln]), 64'(exp_rd));
      check_eq($sformatf("L%0d stall strobe", ln), 64'(wr_en[ln] | rd_en[ln]), 64'd0);
      check_eq($sformatf("L%0d stall cmd_ready", ln), 64'(cmd_ready[ln]), 64'd0);
    end
    rsp_ready[ln] = 1'b1;
    cmd_valid[ln] = 1'b0;
    @(negedge reg_clk);
    rsp_ready[ln] = 1'b0;
    check_eq($sformatf("L%0d rsp_valid drop", ln), 64'(rsp_valid[ln]), 64'd0);
    check_eq($sformatf("L%0d cmd_ready return", ln), 64'(cmd_ready[ln]), 64'd1);
    check_eq($sformatf("L%0d busy idle", ln), 64'(busy[ln]), 64'd0);
    $display("lane %0d %s addr %02h wdata %08h rdata %08h stall %0d", ln,
             c.we ? "WRITE" : "READ ", c.addr, c.wdata, exp_rd, stall);
  endtask

  task automatic mid_read_reset(input int ln);
    cmd_valid[ln] = 1'b1;
    cmd_we[ln]    = 1'b0;
    cmd_addr[ln]  = 8'h07;
    @(negedge reg_clk);
    check_eq($sformatf("L%0d reset-test rd strobe", ln), 64'(rd_en[ln]), 64'd1);
    cmd_valid[ln] = 1'b0;
    repeat (2) @(negedge reg_clk);
    rst[ln] = 1'b1;
    #1;
    check_all_zero(ln, "mid reset");
    @(negedge reg_clk);
    rst[ln] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge reg_clk);
      check_eq($sformatf("L%0d post-reset rsp", ln), 64'(rsp_valid[ln]), 64'd0);
      check_eq($sformatf("L%0d post-reset busy", ln), 64'(busy[ln]), 64'd0);
    end
    $display("lane %0d RESET during RD_WAIT", ln);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    csr_init_cmd_t c;
    int stall;
    for (int ln = 0; ln < NL; ln++) begin
      rst[ln] = 1'b1;
      junk_cmd(ln, 1'b0);
      rsp_ready[ln] = 1'b0;
      rd_data[ln]   = '0;
      for (int a = 0; a < 256; a++) mem[ln][a] = $urandom;
    end
    mem[0][1] = 32'hC000_0015;
    mem[1][1] = 32'hC000_0015;
    mem[0][5] = 32'hFFFF_0000;
    mem[1][5] = 32'hFFFF_0000;
    repeat (3) @(negedge reg_clk);
    for (int ln = 0; ln < NL; ln++) check_all_zero(ln, "reset");
    for (int ln = 0; ln < NL; ln++) rst[ln] = 1'b0;
    #1;
    for (int ln = 0; ln < NL; ln++)
      check_eq($sformatf("L%0d ready before edge", ln), 64'(cmd_ready[ln]), 64'd0);
    @(negedge reg_clk);
    for (int ln = 0; ln < NL; ln++)
      check_eq($sformatf("L%0d ready after reset", ln), 64'(cmd_ready[ln]), 64'd1);

    for (int ln = 0; ln < NL; ln++) begin
      c = '{we: 1'b1, addr: 8'h00, wdata: 32'h0002_8005, mask: 32'hFFFF_FFFF};
      do_txn(ln, c, 0);
      c = '{we: 1'b0, addr: 8'h01, wdata: 32'h0, mask: 32'hFFFF_FFFF};
      do_txn(ln, c, 0);
      c = '{we: 1'b0, addr: 8'h00, wdata: 32'h0, mask: 32'hFFFF_FFFF};
      do_txn(ln, c, 10);
`ifdef CSR_INIT_RMW_EN
      c = '{we: 1'b1, addr: 8'h05, wdata: 32'h0000_00AB, mask: 32'h0000_00FF};
      do_txn(ln, c, 0);
      c = '{we: 1'b1, addr: 8'h06, wdata: 32'h1234_5678, mask: 32'h0};
      do_txn(ln, c, 0);
`endif
      if (ln == 1) mid_read_reset(ln);
      for (int t = 0; t < 25; t++) begin
        c.we    = 1'($urandom);
        c.addr  = AW'($urandom_range(0, 15));
        c.wdata = $urandom;
        case ($urandom_range(0, 2))
          0:       c.mask = 32'hFFFF_FFFF;
          1:       c.mask = 32'h0;
          default: c.mask = $urandom;
        endcase
        stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
        do_txn(ln, c, stall);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/csr_initiator.md
Name: csr_initiator

Overview:
- Bus-master end of the CSR interface.
- Converts a valid/ready command stream (from a debug UART bridge, boot sequencer or test controller) into single-cycle reg_wr_en/reg_rd_en strobes towards a generated CSR map.
- Collects registered read data and returns it on a valid/ready response stream.
- One transaction in flight at a time.

Parameters:
- ADDR_W, 8: CSR address width.
- DATA_W, 32: CSR data width.
- RD_LATENCY, 1: cycles from the reg_rd_en_o strobe to valid reg_rd_data_i; legal range 1..7.

Ports:
- reg_clk_i  in  1  CSR clock.
- reg_rst_i  in  1  reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDR_W  target address.
- cmd_wdata_i  in  DATA_W  write data.
- cmd_mask_i  in  DATA_W  bit-enable mask; present only with CSR_INIT_RMW_EN.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_we_o  out  1  echo of the command type.
- rsp_rdata_o  out  DATA_W  read data; 0 for plain writes.
- reg_wr_en_o  out  1  write strobe.
- reg_rd_en_o  out  1  read strobe.
- reg_addr_o  out  ADDR_W  CSR address.
- reg_wr_data_o  out  DATA_W  CSR write data.
- reg_rd_data_i  in  DATA_W  CSR read data.
- busy_o  out  1  high whenever state is not IDLE.

Behaviour:
- Clocking and reset: clock reg_clk_i; reset reg_rst_i, asynchronous, active-high.
- Reset values: every output 0, state IDLE, all internal registers 0.
- cmd_ready_o is registered; it rises on the first clock edge after reset deasserts.
- States: IDLE, WR, RD, RD_WAIT, RSP (plus MERGE with the optional feature).
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i && cmd_ready_o, latch we/addr/wdata(/mask) and drop cmd_ready_o.
  - Go to WR if we = 1, else RD.
- WR:
  - reg_wr_en_o = 1 for exactly one cycle, with reg_addr_o and reg_wr_data_o driven.
  - Next state RSP, with rsp_rdata_o = 0 and rsp_we_o = 1.
- RD:
  - reg_rd_en_o = 1 for exactly one cycle, with reg_addr_o driven.
  - Load the wait counter with RD_LATENCY-1, then go to RD_WAIT.
- RD_WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, capture reg_rd_data_i into rsp_rdata_o and go to RSP.
  - With RD_LATENCY = 1, capture occurs on the cycle after the strobe.
- RSP:
  - rsp_valid_o = 1, with rsp_rdata_o and rsp_we_o stable.
  - On rsp_ready_i go to IDLE; cmd_ready_o = 1 on the next cycle.
  - rsp_ready_i held low stalls indefinitely; no new command is accepted meanwhile.
- Strobe rules:
  - reg_wr_en_o and reg_rd_en_o are registered outputs.
  - They are never high together and never high on two consecutive cycles.
  - Each strobe is exactly one cycle per access; this preserves clear-on-read side effects in the target.
- reg_addr_o and reg_wr_data_o are registered at acceptance and hold their value until the next acceptance.
- Throughput with rsp_ready_i tied high:
  - Write: 3 cycles per command.
  - Read: 3 + RD_LATENCY cycles per command.
- reg_rd_data_i is ignored outside the capture cycle.
- Reset mid-operation: strobes and rsp_valid_o drop asynchronously; the in-flight command is discarded with no response; state returns to IDLE.
- cmd_* inputs may change freely while cmd_ready_o = 0.

Optional Feature:
- Macro: CSR_INIT_RMW_EN.
- Defined:
  - cmd_mask_i port exists.
  - A write with mask = all-ones follows the plain WR path.
  - Any other write runs RD, then RD_WAIT, then MERGE, then WR.
  - MERGE computes data = (rd & ~mask) | (wdata & mask) into reg_wr_data_o, taking one cycle.
  - WR then strobes the merged data.
  - rsp_rdata_o returns the pre-write value read back.
  - A write with mask = 0 still performs the read, then writes back the unchanged value.
- Undefined: no mask port, no MERGE state; every write is a direct write.

Decomposition:
- Package csr_init_pkg holds:
  - enum csr_init_state_t {IDLE, WR, RD, RD_WAIT, MERGE, RSP};
  - localparam RD_CNT_W = 3;
  - struct csr_init_cmd_t {we, addr, wdata, mask}.
- No sub-module: a single FSM plus datapath registers.

Test Plan:
- Reset, then write addr 0x00 data 0x0002_8005 -> one-cycle reg_wr_en_o with reg_addr_o = 0x00 and reg_wr_data_o = 0x0002_8005 on cycle 2 after acceptance; rsp_valid_o on cycle 3 with rdata 0, we = 1.
- Read addr 0x01, RD_LATENCY = 1, model returns 0xC000_0015 -> single reg_rd_en_o pulse; rsp_rdata_o = 0xC000_0015 two cycles after the strobe.
- RD_LATENCY = 4, model drives junk except on strobe+4 -> only the strobe+4 value is captured.
- Back-to-back commands with rsp_ready_i low for 10 cycles -> cmd_ready_o stays 0, no extra strobes; one strobe follows release.
- Assert reg_rst_i during RD_WAIT -> all outputs 0 immediately; no response after reset; the next command works normally.
- With CSR_INIT_RMW_EN: memory holds 0xFFFF_0000, write wdata 0x0000_00AB, mask 0x0000_00FF -> strobes occur in order read then write; written value = 0xFFFF_00AB; rsp_rdata_o = 0xFFFF_0000.
